// File: rtl/cache_way_allocator_pkg.sv
// Shared widths, allocator state encoding and address-slice helpers for the
// 2-way cache tag/allocation logic.
package cache_types;

   localparam int TAG_W = 24;
   localparam int IDX_W = 3;
   localparam int OFF_W = 5;
   localparam int SETS  = 1 << IDX_W;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2
   } alloc_state_t;

   function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] addr);
      return addr[31:OFF_W+IDX_W];
   endfunction

   function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] addr);
      return addr[OFF_W+IDX_W-1:OFF_W];
   endfunction

   function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                             input logic [IDX_W-1:0] idx);
      return {tag, idx, {OFF_W{1'b0}}};
   endfunction

endpackage

// File: rtl/cache_way_allocator_way_state_array.sv
// Per-way tag/valid/dirty storage: combinational read, one synchronous write
// port that can fill a line, set dirty or clear dirty.
module way_state_array
   import cache_types::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [TAG_W-1:0] rd_tag,
   output logic             rd_valid,
   output logic             rd_dirty,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             fill_en,
   input  logic [TAG_W-1:0] fill_tag,
   input  logic             set_dirty,
   input  logic             clr_dirty
);

   logic [SETS-1:0][TAG_W-1:0] tag_q, tag_d;
   logic [SETS-1:0]            valid_q, valid_d;
   logic [SETS-1:0]            dirty_q, dirty_d;

   assign rd_tag   = tag_q[rd_idx];
   assign rd_valid = valid_q[rd_idx];
   assign rd_dirty = dirty_q[rd_idx];

   // A fill always leaves the new line clean, so it wins over dirty updates.
   always_comb begin
      tag_d   = tag_q;
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (fill_en) begin
         tag_d[wr_idx]   = fill_tag;
         valid_d[wr_idx] = 1'b1;
         dirty_d[wr_idx] = 1'b0;
      end else if (clr_dirty) begin
         dirty_d[wr_idx] = 1'b0;
      end else if (set_dirty) begin
         dirty_d[wr_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q   <= '0;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         tag_q   <= tag_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

endmodule

// File: rtl/cache_way_allocator.sv
// Miss handling for the 2-way cache: owns tag/valid/dirty/LRU state, picks the
// victim, and sequences writeback then fetch over the pmem port.
//
// state     | meaning
// IDLE      | serve hits, update LRU/dirty, detect misses
// WRITEBACK | dirty victim line being written to pmem
// FETCH     | new line being read from pmem into the victim way
module cache_way_allocator
   import cache_types::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      mem_address,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             hit,
   input  logic             hit_way,
   output logic [TAG_W-1:0] tag_0,
   output logic [TAG_W-1:0] tag_1,
   output logic             valid_0,
   output logic             valid_1,
   output logic             pmem_read,
   output logic             pmem_write,
   output logic [31:0]      pmem_address,
   input  logic             pmem_resp,
   output logic             data_load,
   output logic             data_way,
   output logic             busy
);

   alloc_state_t    state_q, state_d;
   logic            victim_q, victim_d;
   logic [SETS-1:0] lru_q, lru_d;
   logic            pmem_read_q, pmem_read_d;
   logic            pmem_write_q, pmem_write_d;
   logic [31:0]     pmem_address_q, pmem_address_d;

   logic [IDX_W-1:0] idx;
   logic             req;
   logic             dirty_0, dirty_1;
   logic             lru_way;
   logic             vict_valid, vict_dirty;
   logic [TAG_W-1:0] vict_tag;
   logic [1:0]       fill_en, set_dirty, clr_dirty;
   logic             data_load_c;

   assign idx        = idx_of(mem_address);
   assign req        = mem_read | mem_write;
   assign lru_way    = lru_q[idx];
   assign vict_valid = lru_way ? valid_1 : valid_0;
   assign vict_dirty = lru_way ? dirty_1 : dirty_0;
   assign vict_tag   = lru_way ? tag_1 : tag_0;

   way_state_array u_way0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_idx    (idx),
      .rd_tag    (tag_0),
      .rd_valid  (valid_0),
      .rd_dirty  (dirty_0),
      .wr_idx    (idx),
      .fill_en   (fill_en[0]),
      .fill_tag  (tag_of(mem_address)),
      .set_dirty (set_dirty[0]),
      .clr_dirty (clr_dirty[0])
   );

   way_state_array u_way1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_idx    (idx),
      .rd_tag    (tag_1),
      .rd_valid  (valid_1),
      .rd_dirty  (dirty_1),
      .wr_idx    (idx),
      .fill_en   (fill_en[1]),
      .fill_tag  (tag_of(mem_address)),
      .set_dirty (set_dirty[1]),
      .clr_dirty (clr_dirty[1])
   );

   always_comb begin
      state_d        = state_q;
      victim_d       = victim_q;
      lru_d          = lru_q;
      pmem_read_d    = pmem_read_q;
      pmem_write_d   = pmem_write_q;
      pmem_address_d = pmem_address_q;
      fill_en        = 2'b00;
      set_dirty      = 2'b00;
      clr_dirty      = 2'b00;
      data_load_c    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req && hit) begin
               lru_d[idx] = ~hit_way;
               if (mem_write) set_dirty[hit_way] = 1'b1;
            end else if (req) begin
               victim_d = lru_way;
               if (vict_valid && vict_dirty) begin
                  state_d        = WRITEBACK;
                  pmem_write_d   = 1'b1;
                  pmem_address_d = line_addr(vict_tag, idx);
               end else begin
                  state_d        = FETCH;
                  pmem_read_d    = 1'b1;
                  pmem_address_d = line_addr(tag_of(mem_address), idx);
               end
            end
         end
         WRITEBACK: begin
            if (pmem_resp) begin
               clr_dirty[victim_q] = 1'b1;
               state_d             = FETCH;
               pmem_write_d        = 1'b0;
               pmem_read_d         = 1'b1;
               pmem_address_d      = line_addr(tag_of(mem_address), idx);
            end
         end
         FETCH: begin
            // LRU is left alone here; the post-fill hit cycle updates it.
            if (pmem_resp) begin
               data_load_c       = 1'b1;
               fill_en[victim_q] = 1'b1;
               state_d           = IDLE;
               pmem_read_d       = 1'b0;
               pmem_address_d    = '0;
            end
         end
         default: begin
            state_d        = IDLE;
            pmem_read_d    = 1'b0;
            pmem_write_d   = 1'b0;
            pmem_address_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         victim_q       <= 1'b0;
         lru_q          <= '0;
         pmem_read_q    <= 1'b0;
         pmem_write_q   <= 1'b0;
         pmem_address_q <= '0;
      end else begin
         state_q        <= state_d;
         victim_q       <= victim_d;
         lru_q          <= lru_d;
         pmem_read_q    <= pmem_read_d;
         pmem_write_q   <= pmem_write_d;
         pmem_address_q <= pmem_address_d;
      end
   end

   assign pmem_read    = pmem_read_q;
   assign pmem_write   = pmem_write_q;
   assign pmem_address = pmem_address_q;
   assign data_load    = data_load_c;
   assign data_way     = victim_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_cache_way_allocator.sv
// Scoreboard bench for cache_way_allocator: the bench plays CPU, tag comparator
// and pmem; pmem requests and line loads are checked against a queue.
module tb_cache_way_allocator;
   import cache_types::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [31:0]      mem_address;
   logic             mem_read, mem_write;
   logic             hit, hit_way;
   logic [TAG_W-1:0] tag_0, tag_1;
   logic             valid_0, valid_1;
   logic             pmem_read, pmem_write;
   logic [31:0]      pmem_address;
   logic             pmem_resp;
   logic             data_load, data_way, busy;

   logic auto_resp = 1'b0;
   logic man_resp  = 1'b0;
   logic resp_en   = 1'b1;
   assign pmem_resp = auto_resp | man_resp;

   cache_way_allocator dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem_address  (mem_address),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .hit          (hit),
      .hit_way      (hit_way),
      .tag_0        (tag_0),
      .tag_1        (tag_1),
      .valid_0      (valid_0),
      .valid_1      (valid_1),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_resp    (pmem_resp),
      .data_load    (data_load),
      .data_way     (data_way),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Comparator stand-in
   logic [TAG_W-1:0] req_tag;
   assign req_tag = mem_address[31:8];
   assign hit     = (valid_0 && tag_0 == req_tag) || (valid_1 && tag_1 == req_tag);
   assign hit_way = valid_1 && (tag_1 == req_tag);

   localparam logic [1:0] EV_WR = 2'd1, EV_RD = 2'd2, EV_LD = 2'd3;
   typedef struct {
      logic [1:0]  kind;
      logic [31:0] val;
   } ev_t;
   ev_t exp_q[$];

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] kind, input logic [31:0] val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic compare_ev(input logic [1:0] kind, input logic [31:0] val);
      ev_t e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_event: got kind %0d value %h expected none", kind, val);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", 32'(kind), 32'(e.kind));
         check("event_value", val, e.val);
      end
   endtask

   // Monitor
   logic prev_r = 1'b0, prev_w = 1'b0;
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (pmem_read && pmem_write) begin
            total++;
            bad++;
            $display("FAIL pmem_exclusive: got read=1 write=1 expected at most one");
         end
         if (pmem_write && !prev_w) compare_ev(EV_WR, pmem_address);
         if (pmem_read && !prev_r)  compare_ev(EV_RD, pmem_address);
         if (data_load)             compare_ev(EV_LD, 32'(data_way));
      end
      prev_r = pmem_read;
      prev_w = pmem_write;
   end

   // pmem responder: completes each request two cycles after it appears
   initial begin
      int wcnt;
      wcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (auto_resp) begin
            auto_resp = 1'b0;
         end else if (resp_en && (pmem_read || pmem_write)) begin
            wcnt++;
            if (wcnt >= 2) begin
               auto_resp = 1'b1;
               wcnt      = 0;
            end
         end
      end
   end

   task automatic access(input logic [31:0] a, input logic wr, input logic both);
      bit done;
      done = 1'b0;
      @(negedge clk);
      mem_address = a;
      mem_write   = wr;
      mem_read    = !wr || both;
      #1;
      for (int i = 0; i < 100 && !done; i++) begin
         if (hit && !busy) begin
            @(posedge clk);
            done = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      check("access_done", 32'(done), 32'd1);
      @(negedge clk);
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   initial begin
      bit seen;
      rst_n       = 1'b1;
      mem_address = 32'h0000_0120;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      #2 rst_n = 1'b0;
      #10;
      check("rst_tag_0", 32'(tag_0), 32'd0);
      check("rst_tag_1", 32'(tag_1), 32'd0);
      check("rst_valid_0", 32'(valid_0), 32'd0);
      check("rst_valid_1", 32'(valid_1), 32'd0);
      check("rst_pmem_read", 32'(pmem_read), 32'd0);
      check("rst_pmem_write", 32'(pmem_write), 32'd0);
      check("rst_pmem_address", pmem_address, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_data_load", 32'(data_load), 32'd0);
      check("rst_data_way", 32'(data_way), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Cold miss in set 1 -> way 0, no writeback
      push(EV_RD, 32'h0000_0120); push(EV_LD, 32'd0);
      access(32'h0000_0120, 1'b0, 1'b0);
      check("fill_tag_0", 32'(tag_0), 32'h1);
      check("fill_valid_0", 32'(valid_0), 32'd1);
      check("fill_valid_1", 32'(valid_1), 32'd0);

      // Write hit: dirties way 0, LRU -> way 1, no pmem traffic
      access(32'h0000_0120, 1'b1, 1'b0);

      push(EV_RD, 32'h0000_0220); push(EV_LD, 32'd1);
      access(32'h0000_0220, 1'b0, 1'b0);
      check("fill_tag_1", 32'(tag_1), 32'h2);

      // Dirty victim way 0 -> writeback of old line then fetch
      push(EV_WR, 32'h0000_0120); push(EV_RD, 32'h0000_0320); push(EV_LD, 32'd0);
      access(32'h0000_0320, 1'b0, 1'b0);
      check("wb_fill_tag_0", 32'(tag_0), 32'h3);

      // Clean valid victim way 1 -> fetch only
      push(EV_RD, 32'h0000_0420); push(EV_LD, 32'd1);
      access(32'h0000_0420, 1'b0, 1'b0);
      check("clean_fill_tag_1", 32'(tag_1), 32'h4);

      // Way 0 was refilled clean, so no writeback now
      push(EV_RD, 32'h0000_0520); push(EV_LD, 32'd0);
      access(32'h0000_0520, 1'b0, 1'b0);
      check("refill_tag_0", 32'(tag_0), 32'h5);

      // Read+write together acts as a write
      push(EV_RD, 32'h0000_0A40); push(EV_LD, 32'd0);
      access(32'h0000_0A40, 1'b1, 1'b1);
      push(EV_RD, 32'h0000_0B40); push(EV_LD, 32'd1);
      access(32'h0000_0B40, 1'b0, 1'b0);
      push(EV_WR, 32'h0000_0A40); push(EV_RD, 32'h0000_0C40); push(EV_LD, 32'd0);
      access(32'h0000_0C40, 1'b0, 1'b0);

      // Request dropped during FETCH: fill completes, LRU untouched
      push(EV_RD, 32'h0000_0160); push(EV_LD, 32'd0);
      @(negedge clk);
      mem_address = 32'h0000_0160;
      mem_read    = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (pmem_read) seen = 1'b1;
      end
      check("drop_fetch_started", 32'(seen), 32'd1);
      mem_read = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (!busy) seen = 1'b1;
      end
      check("drop_returned_idle", 32'(seen), 32'd1);
      check("drop_fill_tag_0", 32'(tag_0), 32'h1);
      check("drop_fill_valid_0", 32'(valid_0), 32'd1);
      push(EV_RD, 32'h0000_0260); push(EV_LD, 32'd0);
      access(32'h0000_0260, 1'b0, 1'b0);

      // Async reset during FETCH (victim way 1 in set 1)
      resp_en = 1'b0;
      push(EV_RD, 32'h0000_0620);
      @(negedge clk);
      mem_address = 32'h0000_0620;
      mem_read    = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (pmem_read) seen = 1'b1;
      end
      check("rst_fetch_started", 32'(seen), 32'd1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("async_pmem_read", 32'(pmem_read), 32'd0);
      check("async_pmem_write", 32'(pmem_write), 32'd0);
      check("async_busy", 32'(busy), 32'd0);
      check("async_valid_0", 32'(valid_0), 32'd0);
      check("async_valid_1", 32'(valid_1), 32'd0);
      check("async_data_way", 32'(data_way), 32'd0);
      check("async_pmem_address", pmem_address, 32'd0);
      mem_read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      man_resp = 1'b1;
      #1;
      check("stray_resp_data_load", 32'(data_load), 32'd0);
      @(negedge clk);
      man_resp = 1'b0;
      @(posedge clk);
      #1;
      check("stray_resp_busy", 32'(busy), 32'd0);
      check("stray_resp_pmem_read", 32'(pmem_read), 32'd0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cache_way_allocator.md
Name: cache_way_allocator

Overview:
- Write-side counterpart of the 2-way tag comparator. Owns the tag, valid, dirty and LRU state for every set of the 2-way set-associative cache.
- Presents tag_0/tag_1/valid_0/valid_1 for the current index to the comparator.
- On a miss, sequences victim writeback and line fetch over the physical-memory interface, then writes the new tag and valid into the victim way.
- Sits between the CPU-side request, the tag comparator and the pmem port; the data array is external.

Parameters:
- TAG_W, 24, tag width (address bits [31:8])
- IDX_W, 3, set-index width (address bits [7:5]); 2**IDX_W sets
- OFF_W, 5, line-offset width (32-byte line)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_address  in  32  CPU request address; held stable until the request completes
- mem_read  in  1  CPU read request
- mem_write  in  1  CPU write request
- hit  in  1  comparator hit
- hit_way  in  1  comparator way select (comparator cmp_rst output)
- tag_0  out  TAG_W  way-0 tag at mem_address index (combinational read)
- tag_1  out  TAG_W  way-1 tag at mem_address index
- valid_0  out  1  way-0 valid at index
- valid_1  out  1  way-1 valid at index
- pmem_read  out  1  line fetch request
- pmem_write  out  1  line writeback request
- pmem_address  out  32  line-aligned pmem address
- pmem_resp  in  1  pmem completion strobe, single cycle
- data_load  out  1  one-cycle strobe: data array captures pmem line into data_way
- data_way  out  1  way the data array writes or reads for pmem traffic (latched victim)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock domain, clk; reset is asynchronous, active-low on rst_n.
- Reset value of every output: 0.
- Reset value of every array: tag, valid, dirty and LRU all 0.
- Reset state: IDLE.
- Reset asserted mid-operation: FSM returns to IDLE and pmem_read/pmem_write drop immediately, without waiting for clk.
- Array reads are combinational at idx = mem_address[7:5]; tag_x, valid_x change in the same cycle as mem_address.
- LRU encoding: lru[idx] = way to evict next.
- FSM states: IDLE, WRITEBACK, FETCH.
- IDLE, request with hit (mem_read|mem_write, hit=1):
  - next edge: lru[idx] <= ~hit_way
  - if mem_write: dirty[hit_way][idx] <= 1
  - stay in IDLE
- IDLE, request with miss (hit=0):
  - latch victim = lru[idx] into data_way
  - go to WRITEBACK if valid[victim][idx] && dirty[victim][idx]
  - otherwise go to FETCH
- mem_read and mem_write both high: treated as a write (sets dirty on hit).
- WRITEBACK:
  - pmem_write = 1, pmem_address = {tag[victim][idx], idx, 5'b0}
  - on pmem_resp: clear dirty[victim][idx], go to FETCH
- FETCH:
  - pmem_read = 1, pmem_address = {mem_address[31:8], idx, 5'b0}
  - on pmem_resp, same cycle: data_load = 1; next edge tag[victim][idx] <= mem_address tag, valid <= 1, dirty <= 0; go to IDLE
- Post-fill: the following cycle the comparator reports a hit in IDLE. The normal hit path then updates LRU and dirty, so total miss latency is 1 cycle beyond the pmem responses.
- pmem_read and pmem_write: never asserted simultaneously; held high until pmem_resp.
- pmem_address: 0 in IDLE.
- pmem_resp outside WRITEBACK/FETCH: ignored.
- Hit path: updates only in IDLE; hit inputs ignored while busy.
- Request deasserted mid-miss: the sequence still completes (line filled); no state is updated on return to IDLE.

Decomposition:
- Shared package cache_types holds TAG_W, IDX_W, OFF_W and the state enum alloc_state_t {IDLE, WRITEBACK, FETCH}.
- The package also holds the address-slice helpers tag_of(), idx_of() and line_addr().
- One sub-module is natural: way_state_array, holding per-way tag/valid/dirty storage with a combinational read and a single synchronous write port with clear.
- Instantiate way_state_array twice. LRU bits stay in cache_way_allocator.

Test Plan:
- Reset then read 0x0000_0120, hit=0:
  - victim way 0, no writeback
  - pmem_read=1 with pmem_address=0x0000_0120
  - resp -> data_load=1, data_way=0
  - next cycle tag_0=0x000001, valid_0=1, lru[1]=0 until the hit, then 1
- Write hit at 0x0000_0120 (hit=1, hit_way=0) -> dirty[0][1]=1, lru[1]=1, busy stays 0.
- Fill way 1 of set 1 with tag 0x000002, dirty way 0; miss at 0x0000_0320 with lru[1]=0:
  - WRITEBACK with pmem_write=1, pmem_address=0x0000_0120
  - resp -> FETCH with pmem_address=0x0000_0320
  - resp -> tag_0=0x000003, dirty cleared
- Miss with clean valid victim -> goes straight to FETCH; pmem_write never asserted.
- rst_n low during FETCH with pmem_read=1:
  - pmem_read drops before the next clk edge
  - all valid=0, busy=0
  - a later pmem_resp pulse is ignored
- Miss, then mem_read drops during FETCH -> line still filled, FSM returns to IDLE, LRU unchanged.
